// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the target and the master.
// Contents: bus field widths, the R/W bit position, the bit-counter width,
// the protocol state encoding and an address-compare helper.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;
   localparam int unsigned I2C_BYTE_W = 8;
   localparam int unsigned I2C_RW_BIT = 0;
   localparam int unsigned I2C_CNT_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_RX_BYTE   = 3'd3,
      ST_RX_ACK    = 3'd4,
      ST_TX_BYTE   = 3'd5,
      ST_TX_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } i2c_state_e;

   // True when the 7-bit address field of an address frame equals addr.
   function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] frame,
                                       input logic [I2C_ADDR_W-1:0] addr);
      return frame[I2C_BYTE_W-1:I2C_BYTE_W-I2C_ADDR_W] == addr;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the raw scl/sda pins and detects bus events.
// Ports:
//   clk, res      system clock, synchronous active-high reset
//   scl, sda      raw bus pins
//   sda_line      synchronized sda level, aligned with the event pulses
//   scl_rise      one-cycle pulse, scl went 0->1
//   scl_fall      one-cycle pulse, scl went 1->0
//   start         one-cycle pulse, sda fell while scl high
//   stop          one-cycle pulse, sda rose while scl high
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic res,
   input  logic scl,
   input  logic sda,
   output logic sda_line,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_hist;
   logic                   sda_hist;
   logic                   scl_now;
   logic                   sda_now;

   assign scl_now  = scl_sync[SYNC_STAGES-1];
   assign sda_now  = sda_sync[SYNC_STAGES-1];
   assign sda_line = sda_hist;

   // Synchronizer and history flops carry no reset: a reset must never
   // fabricate an edge (and thus a false START) from a pin that is low.
   always_ff @(posedge clk) begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_hist <= scl_now;
      sda_hist <= sda_now;
   end

   // Registered event pulses, compared against the history flop.
   always_ff @(posedge clk) begin
      if (res) begin
         scl_rise <= 1'b0;
         scl_fall <= 1'b0;
         start    <= 1'b0;
         stop     <= 1'b0;
      end else begin
         scl_rise <= scl_now & ~scl_hist;
         scl_fall <= ~scl_now & scl_hist;
         start    <= scl_now & scl_hist & sda_hist & ~sda_now;
         stop     <= scl_now & scl_hist & ~sda_hist & sda_now;
      end
   end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address decode, write-byte reception and read-byte supply
// through a byte-level handshake. sda is open-drain (0 or Z), scl input only.
// Ports:
//   clk100mhz, res  system clock, synchronous active-high reset
//   scl             bus clock from the master
//   sda             bus data, driven low or released
//   rx_data         last byte written by the master
//   rx_valid        one-cycle pulse, rx_data updated
//   tx_data         byte to return on a read, sampled 2 clk after tx_req
//   tx_req          one-cycle pulse requesting the next read byte
//   busy            high while addressed, until STOP or NACK
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h2A,
   parameter int unsigned           SYNC_STAGES = 2
) (
   input  logic                  clk100mhz,
   input  logic                  res,
   input  logic                  scl,
   inout  wire                   sda,
   output logic [I2C_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [I2C_BYTE_W-1:0] tx_data,
   output logic                  tx_req,
   output logic                  busy
);

   logic sda_line;
   logic scl_rise;
   logic scl_fall;
   logic start;
   logic stop;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk      (clk100mhz),
      .res      (res),
      .scl      (scl),
      .sda      (sda),
      .sda_line (sda_line),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   i2c_state_e            state_q,    state_d;
   logic [I2C_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [I2C_BYTE_W-1:0] shift_q,    shift_d;
   logic [I2C_BYTE_W-1:0] tx_shift_q, tx_shift_d;
   logic                  phase_q,    phase_d;
   logic                  rw_q,       rw_d;
   logic                  sda_low_q,  sda_low_d;
   logic                  busy_q,     busy_d;
   logic [I2C_BYTE_W-1:0] rx_data_q,  rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  tx_req_q,   tx_req_d;
   logic [1:0]            tx_pipe_q;
   logic [I2C_BYTE_W-1:0] shift_in;

   assign sda      = sda_low_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;

   // State and datapath registers.
   always_ff @(posedge clk100mhz) begin
      if (res) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_shift_q <= '0;
         phase_q    <= 1'b0;
         rw_q       <= 1'b0;
         sda_low_q  <= 1'b0;
         busy_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         tx_pipe_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_shift_q <= tx_shift_d;
         phase_q    <= phase_d;
         rw_q       <= rw_d;
         sda_low_q  <= sda_low_d;
         busy_q     <= busy_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         tx_pipe_q  <= {tx_pipe_q[0], tx_req_q};
      end
   end

   // Next-state and output logic. phase_q marks the second half of an ACK
   // slot: in ADDR_ACK/RX_ACK "we are driving the ACK", in TX_ACK "master
   // ACKed, start the next byte on the coming scl fall".
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_shift_d = tx_shift_q;
      phase_d    = phase_q;
      rw_d       = rw_q;
      sda_low_d  = sda_low_q;
      busy_d     = busy_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      shift_in   = {shift_q[I2C_BYTE_W-2:0], sda_line};

      // tx_data is captured two clocks after the tx_req pulse.
      if (tx_pipe_q[1]) begin
         tx_shift_d = tx_data;
      end

      if (stop) begin
         state_d   = ST_IDLE;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
         phase_d   = 1'b0;
         bit_cnt_d = '0;
      end else if (start) begin
         state_d   = ST_ADDR;
         sda_low_d = 1'b0;
         phase_d   = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sda_low_d = 1'b0;
            end

            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = I2C_CNT_W'(bit_cnt_q + 1'b1);
                  if (bit_cnt_q == '1) begin
                     if (addr_match(shift_in, SLAVE_ADDR)) begin
                        state_d = ST_ADDR_ACK;
                        busy_d  = 1'b1;
                        rw_d    = shift_in[I2C_RW_BIT];
                        phase_d = 1'b0;
                     end else begin
                        state_d = ST_WAIT_STOP;
                        busy_d  = 1'b0;
                     end
                  end
               end
            end

            ST_ADDR_ACK: begin
               if (scl_rise && phase_q && rw_q) begin
                  tx_req_d = 1'b1;
               end else if (scl_fall) begin
                  if (!phase_q) begin
                     sda_low_d = 1'b1;
                     phase_d   = 1'b1;
                  end else begin
                     phase_d = 1'b0;
                     if (rw_q) begin
                        state_d    = ST_TX_BYTE;
                        sda_low_d  = ~tx_shift_q[I2C_BYTE_W-1];
                        tx_shift_d = {tx_shift_q[I2C_BYTE_W-2:0], 1'b0};
                     end else begin
                        state_d   = ST_RX_BYTE;
                        sda_low_d = 1'b0;
                     end
                  end
               end
            end

            ST_RX_BYTE: begin
               if (scl_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = I2C_CNT_W'(bit_cnt_q + 1'b1);
                  if (bit_cnt_q == '1) begin
                     rx_data_d  = shift_in;
                     rx_valid_d = 1'b1;
                     state_d    = ST_RX_ACK;
                     phase_d    = 1'b0;
                  end
               end
            end

            ST_RX_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_low_d = 1'b1;
                     phase_d   = 1'b1;
                  end else begin
                     sda_low_d = 1'b0;
                     phase_d   = 1'b0;
                     state_d   = ST_RX_BYTE;
                  end
               end
            end

            ST_TX_BYTE: begin
               // The counter wraps to 0 on the 8th rise, so a fall seen
               // with a zero count ends the byte.
               if (scl_rise) begin
                  bit_cnt_d = I2C_CNT_W'(bit_cnt_q + 1'b1);
               end else if (scl_fall) begin
                  if (bit_cnt_q == '0) begin
                     sda_low_d = 1'b0;
                     phase_d   = 1'b0;
                     state_d   = ST_TX_ACK;
                  end else begin
                     sda_low_d  = ~tx_shift_q[I2C_BYTE_W-1];
                     tx_shift_d = {tx_shift_q[I2C_BYTE_W-2:0], 1'b0};
                  end
               end
            end

            ST_TX_ACK: begin
               if (scl_rise && !phase_q) begin
                  if (!sda_line) begin
                     tx_req_d = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     state_d = ST_WAIT_STOP;
                     busy_d  = 1'b0;
                  end
               end else if (scl_fall && phase_q) begin
                  phase_d    = 1'b0;
                  state_d    = ST_TX_BYTE;
                  sda_low_d  = ~tx_shift_q[I2C_BYTE_W-1];
                  tx_shift_d = {tx_shift_q[I2C_BYTE_W-2:0], 1'b0};
               end
            end

            ST_WAIT_STOP: begin
               sda_low_d = 1'b0;
               busy_d    = 1'b0;
            end

            default: begin
               state_d   = ST_IDLE;
               sda_low_d = 1'b0;
            end
         endcase
      end
   end

endmodule
